// File: rtl/line_buffer_ctrl.sv
// 3x3 window sequencer over four rotating line buffers for the edge-detection datapath.
// Define LBCTRL_INTR_EN to generate line_done_intr; otherwise it is tied low.
module line_buffer_ctrl #(
    parameter int unsigned LINE_WIDTH = 512,
    parameter int unsigned PTR_W      = $clog2(LINE_WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_pixel,
    input  logic             in_pixel_valid,
    output logic             in_ready,
    input  logic             sched_en,
    output logic [71:0]      pixel_data,
    output logic             pixel_data_valid,
    output logic             line_done_intr
);

    localparam int unsigned NUM_LB = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned WIN_W  = 72;

    localparam logic [PTR_W-1:0] WR_LAST = PTR_W'(LINE_WIDTH - 1);
    localparam logic [PTR_W-1:0] RD_LAST = PTR_W'(LINE_WIDTH - 3);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [SEL_W-1:0]   wr_sel;
    logic [SEL_W-1:0]   rd_sel;
    logic [CNT_W-1:0]   lines_full;
    logic [7:0]         lb [NUM_LB][LINE_WIDTH];
    logic [WIN_W-1:0]   window_c;
    logic               wr_en_c;
    logic               wr_wrap_c;
    logic               rd_done_c;

    assign in_ready  = (lines_full != CNT_W'(4));
    assign wr_en_c   = in_pixel_valid && in_ready;
    assign wr_wrap_c = wr_en_c && (wr_ptr == WR_LAST);
    assign rd_done_c = (state == READ) && (rd_ptr == RD_LAST);

    // Write pointer and buffer select
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            wr_sel <= '0;
        end else if (wr_en_c) begin
            if (wr_ptr == WR_LAST) begin
                wr_ptr <= '0;
                wr_sel <= wr_sel + SEL_W'(1);
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    // Buffer storage; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            lb[wr_sel][wr_ptr] <= in_pixel;
        end
    end

    // Complete-but-unconsumed line count; simultaneous fill and release cancel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lines_full <= '0;
        end else if (wr_wrap_c && !rd_done_c) begin
            lines_full <= lines_full + CNT_W'(1);
        end else if (!wr_wrap_c && rd_done_c) begin
            lines_full <= lines_full - CNT_W'(1);
        end
    end

    // Window gather: byte r*3+c is row r (oldest first), column rd_ptr+c
    always_comb begin
        window_c = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                window_c[(r*3 + c)*8 +: 8] =
                    lb[SEL_W'(rd_sel + SEL_W'(r))][PTR_W'(rd_ptr + PTR_W'(c))];
            end
        end
    end

    // Read sequencer with registered window output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            rd_ptr           <= '0;
            rd_sel           <= '0;
            pixel_data       <= '0;
            pixel_data_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pixel_data_valid <= 1'b0;
                    rd_ptr           <= '0;
                    if ((lines_full >= CNT_W'(3)) && sched_en) begin
                        state <= READ;
                    end
                end
                READ: begin
                    pixel_data       <= window_c;
                    pixel_data_valid <= 1'b1;
                    if (rd_ptr == RD_LAST) begin
                        state  <= IDLE;
                        rd_ptr <= '0;
                        rd_sel <= rd_sel + SEL_W'(1);
                    end else begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    end
                end
            endcase
        end
    end

`ifdef LBCTRL_INTR_EN
    logic intr_q;

    // Pulse aligned with the last window of each line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            intr_q <= 1'b0;
        end else begin
            intr_q <= rd_done_c;
        end
    end

    assign line_done_intr = intr_q;
`else
    assign line_done_intr = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl: directed scenarios plus random traffic
// checked cycle by cycle against an image-level reference model.
module tb_line_buffer_ctrl;

    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_pixel;
    logic        in_pixel_valid;
    logic        in_ready;
    logic        sched_en;
    logic [71:0] pixel_data;
    logic        pixel_data_valid;
    logic        line_done_intr;

    always #5 clk = ~clk;

    line_buffer_ctrl #(.LINE_WIDTH(LW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_pixel         (in_pixel),
        .in_pixel_valid   (in_pixel_valid),
        .in_ready         (in_ready),
        .sched_en         (sched_en),
        .pixel_data       (pixel_data),
        .pixel_data_valid (pixel_data_valid),
        .line_done_intr   (line_done_intr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: every accepted pixel since reset, in raster order
    logic [7:0]  img[$];
    int          lines_read;
    bit          m_reading;
    int          m_col;
    logic        m_valid;
    logic        m_intr;
    logic [71:0] m_data;
    bit          m_rst_cycle;

    // Observations for directed checks
    int          cyc, vcnt, first_idx, last_idx, intr_idx, ready_lows;
    logic [71:0] first_w, last_w;
    bit          prev_intr;
    logic        ready_after_intr;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] pack9(input int b0, input int b1, input int b2,
                                          input int b3, input int b4, input int b5,
                                          input int b6, input int b7, input int b8);
        logic [71:0] w;
        w = {8'(b8), 8'(b7), 8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
        return w;
    endfunction

    function automatic logic [71:0] model_win(input int line, input int col);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3 + c)*8 +: 8] = img[(line + r)*LW + col + c];
        return w;
    endfunction

    function automatic int model_full();
        return img.size() / LW - lines_read;
    endfunction

    task automatic model_step(input bit v, input logic [7:0] p, input bit s, input bit r);
        int full;
        bit acc;
        m_rst_cycle = !r;
        if (!r) begin
            img.delete();
            lines_read = 0;
            m_reading  = 0;
            m_col      = 0;
            m_valid    = 1'b0;
            m_intr     = 1'b0;
            m_data     = '0;
        end else begin
            full = model_full();
            acc  = v && (full != 4);
            if (m_reading) begin
                m_data  = model_win(lines_read, m_col);
                m_valid = 1'b1;
                m_intr  = (m_col == LW - 3);
                if (m_intr) begin
                    m_reading = 0;
                    lines_read++;
                end else begin
                    m_col++;
                end
            end else begin
                m_valid = 1'b0;
                m_intr  = 1'b0;
                if (full >= 3 && s) begin
                    m_reading = 1;
                    m_col     = 0;
                end
            end
            if (acc) img.push_back(p);
        end
    endtask

    task automatic compare_outputs();
        logic exp_intr;
`ifdef LBCTRL_INTR_EN
        exp_intr = m_intr;
`else
        exp_intr = 1'b0;
`endif
        chk("valid", 72'(pixel_data_valid), 72'(m_valid));
        chk("intr",  72'(line_done_intr),   72'(exp_intr));
        chk("ready", 72'(in_ready),         72'(model_full() != 4));
        if (m_valid || m_rst_cycle) chk("data", pixel_data, m_data);
        cyc++;
        if (pixel_data_valid) begin
            vcnt++;
            if (vcnt == 1) begin
                first_idx = cyc;
                first_w   = pixel_data;
            end
            last_idx = cyc;
            last_w   = pixel_data;
        end
        if (line_done_intr) intr_idx = vcnt;
        if (!in_ready) ready_lows++;
        if (prev_intr) ready_after_intr = in_ready;
        prev_intr = line_done_intr;
    endtask

    task automatic step(input bit v, input logic [7:0] p, input bit s, input bit r);
        in_pixel_valid = v;
        in_pixel       = p;
        sched_en       = s;
        rst_n          = r;
        @(posedge clk);
        model_step(v, p, s, r);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic clear_obs();
        cyc = 0; vcnt = 0; first_idx = 0; last_idx = 0; intr_idx = 0; ready_lows = 0;
        first_w = '0; last_w = '0; prev_intr = 0; ready_after_intr = 1'b0;
    endtask

    task automatic do_reset();
        step(0, 8'd0, 0, 0);
        step(0, 8'd0, 0, 0);
        clear_obs();
    endtask

    initial begin
        logic [71:0] w_first, w_last;
        int exp_intr_idx;
        bit found;
        w_first = pack9(0, 1, 2, 8, 9, 10, 16, 17, 18);
        w_last  = pack9(5, 6, 7, 13, 14, 15, 21, 22, 23);
`ifdef LBCTRL_INTR_EN
        exp_intr_idx = 6;
`else
        exp_intr_idx = 0;
`endif
        in_pixel_valid = 1'b0;
        in_pixel       = 8'd0;
        sched_en       = 1'b0;
        rst_n          = 1'b0;
        clear_obs();
        @(negedge clk);

        // Three lines streamed with scheduling enabled
        do_reset();
        chk("rst_data", pixel_data, 72'd0);
        for (int i = 0; i < 24; i++) step(1, 8'(i), 1, 1);
        repeat (15) step(0, 8'd0, 1, 1);
        chk("s1_count", 72'(vcnt), 72'd6);
        chk("s1_span", 72'(last_idx - first_idx + 1), 72'd6);
        chk("s1_first", first_w, w_first);
        chk("s1_last", last_w, w_last);
        chk("s1_intr_pos", 72'(intr_idx), 72'(exp_intr_idx));
        chk("s1_lines_full", 72'(dut.lines_full), 72'd2);

        // One pixel short of three lines
        do_reset();
        for (int i = 0; i < 23; i++) step(1, 8'(i), 1, 1);
        repeat (10) step(0, 8'd0, 1, 1);
        chk("s2_count", 72'(vcnt), 72'd0);
        chk("s2_ready_lows", 72'(ready_lows), 72'd0);

        // Fill all four buffers with scheduling held off
        do_reset();
        for (int i = 0; i < 40; i++) step(1, 8'(i), 0, 1);
        chk("s3_full4", 72'(dut.lines_full), 72'd4);
        chk("s3_ready_low", 72'(in_ready), 72'd0);
        step(0, 8'd0, 1, 1);
        repeat (12) step(0, 8'd0, 0, 1);
        chk("s3_count", 72'(vcnt), 72'd6);
        chk("s3_first", first_w, w_first);
        chk("s3_last", last_w, w_last);
`ifdef LBCTRL_INTR_EN
        chk("s3_ready_after_intr", 72'(ready_after_intr), 72'd1);
`endif
        chk("s3_lines_full", 72'(dut.lines_full), 72'd3);
        clear_obs();
        step(0, 8'd0, 1, 1);
        repeat (12) step(0, 8'd0, 0, 1);
        chk("s3_line3_last", last_w, pack9(13, 14, 15, 21, 22, 23, 29, 30, 31));
        chk("s3_lines_full2", 72'(dut.lines_full), 72'd2);

        // Continuous random stream, reads overlap writes
        do_reset();
        for (int i = 0; i < 48; i++) step(1, 8'($urandom), 1, 1);
        repeat (40) step(0, 8'd0, 1, 1);
        chk("s4_count", 72'(vcnt), 72'd24);
        chk("s4_lines_full", 72'(dut.lines_full), 72'd2);

        // Reset during the third window of a line
        do_reset();
        for (int i = 0; i < 24; i++) step(1, 8'(i + 100), 1, 1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (vcnt == 2) found = 1;
            else step(0, 8'd0, 1, 1);
        end
        chk("s5_wait", 72'(found), 72'd1);
        step(0, 8'd0, 1, 0);
        chk("s5_valid", 72'(pixel_data_valid), 72'd0);
        chk("s5_intr", 72'(line_done_intr), 72'd0);
        chk("s5_ready", 72'(in_ready), 72'd1);
        chk("s5_lines_full", 72'(dut.lines_full), 72'd0);
        clear_obs();
        repeat (3) step(0, 8'd0, 1, 1);
        for (int i = 0; i < 23; i++) step(1, 8'($urandom), 1, 1);
        repeat (8) step(0, 8'd0, 1, 1);
        chk("s5_no_window", 72'(vcnt), 72'd0);
        step(1, 8'($urandom), 1, 1);
        repeat (12) step(0, 8'd0, 1, 1);
        chk("s5_resume", 72'(vcnt), 72'd6);

        // Random valid/sched traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 75, 8'($urandom), $urandom_range(0, 99) < 80, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencing controller for the 3x3 edge-detection datapath. Accepts a raster pixel stream one byte per cycle and stores it in four rotating line buffers. Once three complete lines are held, it issues one 72-bit 3x3 window per cycle with a valid strobe, sized and ordered to drive the convolution stage directly. Signals line completion so the upstream DMA can refill the freed buffer.

## Interface
- LINE_WIDTH, 512, pixels per image line; must be at least 4.
- PTR_W, $clog2(LINE_WIDTH), width of the line pointers.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_pixel  in  8  incoming pixel, unsigned.
- in_pixel_valid  in  1  in_pixel is valid this cycle.
- in_ready  out  1  controller can accept a pixel; a valid pixel presented while this is low is dropped.
- sched_en  in  1  permits the start of a new read line; a line already being read always completes.
- pixel_data  out  72  3x3 window. Byte i (bits i*8+:8) holds row i/3, column i%3. Row 0 is the oldest line; column 0 is the leftmost pixel.
- pixel_data_valid  out  1  pixel_data is valid this cycle.
- line_done_intr  out  1  one-cycle pulse when a line buffer is freed.

## Operation
- Storage: four buffers LB0..LB3, each LINE_WIDTH x 8 bits.
- Write side:
  - Pixel accepted when in_pixel_valid && in_ready; it is written to LB[wr_sel][wr_ptr] and wr_ptr increments.
  - When wr_ptr reaches LINE_WIDTH-1 and a pixel is accepted, wr_ptr wraps to 0, wr_sel advances mod 4, and lines_full increments.
- lines_full (range 0..4) counts complete, unconsumed lines.
  - A line-write completion and a read-line completion in the same cycle leave it unchanged.
  - in_ready = (lines_full != 4).
- FSM, states IDLE and READ:
  - IDLE -> READ when lines_full >= 3 && sched_en. rd_ptr = 0.
  - READ: each cycle issues the window at rd_ptr, then increments rd_ptr.
  - After issuing rd_ptr == LINE_WIDTH-3: go to IDLE, rd_ptr -> 0, rd_sel advances mod 4, lines_full decrements.
  - Each line therefore yields LINE_WIDTH-2 windows (valid convolution, no padding).
  - At least one IDLE cycle separates consecutive read lines.
- Window rows are LB[rd_sel], LB[(rd_sel+1)%4] and LB[(rd_sel+2)%4]. Columns are rd_ptr, rd_ptr+1 and rd_ptr+2.
- The write side never targets a buffer being read. Buffer LB[rd_sel] is released only at read-line completion.
- Reset mid-operation aborts any read line. All state returns to reset values and buffer contents are don't-care.

## Timing
- Reset values:
  - pixel_data = 0, pixel_data_valid = 0, line_done_intr = 0, in_ready = 1.
  - FSM = IDLE; all pointers, selects and lines_full = 0.
- Buffer reads are combinational. pixel_data and pixel_data_valid are registered, so there is 1-cycle latency from the issue cycle.
- Sequence from input to first window:
  - Cycle N: the pixel completing the third line is accepted; lines_full becomes 3 at N+1.
  - Cycle N+1: FSM evaluates IDLE -> READ; state is READ at N+2.
  - Cycle N+3: first pixel_data_valid.
- pixel_data_valid stays high for LINE_WIDTH-2 consecutive cycles per line.
- line_done_intr is high in the same cycle as the last pixel_data_valid of a line.
- in_ready is combinational from lines_full. It rises the cycle after read-line completion.
- Downstream has no backpressure. The convolution stage must accept a window every valid cycle.

## Configuration
- LBCTRL_INTR_EN defined: line_done_intr is generated as specified.
- LBCTRL_INTR_EN undefined: line_done_intr is tied to 0 and its generation logic is removed. All other behaviour is identical.

## Test plan
All scenarios use LINE_WIDTH=8 and LBCTRL_INTR_EN defined.
- After reset with sched_en=1, stream pixels 0..23, one per cycle. Required: 6 consecutive valid windows, with the first window at bytes 0..8 = {0,1,2,8,9,10,16,17,18} and the last = {5,6,7,13,14,15,21,22,23}. line_done_intr pulses with the 6th window. lines_full ends at 2.
- Stream only 23 pixels. Required: pixel_data_valid never asserts and in_ready stays 1.
- With sched_en=0, stream 40 pixels. Required: lines_full=4 after pixel 31; in_ready drops; pixels 32..39 are dropped. Then raise sched_en. Required: windows from lines 0-2 are issued; in_ready returns to 1 the cycle after the intr pulse; lines_full=3.
- Stream 48 pixels continuously with sched_en=1. Required: the read-line completion coinciding with a line-write completion leaves lines_full unchanged; 4 lines of 6 windows each; every window's contents are correct.
- Assert rst_n=0 for one cycle during the 3rd window of a READ line. Required: the next cycle shows pixel_data_valid=0, line_done_intr=0, in_ready=1 and FSM IDLE, and no window is issued until 3 new lines have been written.
